// File: rtl/icache_fetch_responder_pkg.sv
// Shared types, default geometry and address-field helpers for the
// direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DEF_NUM_LINES  = 64;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_OFF_W      = $clog2(DEF_LINE_WORDS);
  localparam int DEF_IDX_W      = $clog2(DEF_NUM_LINES);
  localparam int DEF_TAG_W      = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W - 2;

  // Callers pass widths so one set of helpers serves any geometry.
  function automatic logic [31:0] addr_field(input logic [63:0] addr, input int lsb,
                                             input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return 32'((addr >> lsb) & mask);
  endfunction

  function automatic logic [31:0] offset_of(input logic [63:0] addr, input int off_w);
    return addr_field(addr, 2, off_w);
  endfunction

  function automatic logic [31:0] index_of(input logic [63:0] addr, input int off_w,
                                           input int idx_w);
    return addr_field(addr, 2 + off_w, idx_w);
  endfunction

  function automatic logic [31:0] tag_of(input logic [63:0] addr, input int off_w,
                                         input int idx_w, input int tag_w);
    return addr_field(addr, 2 + off_w + idx_w, tag_w);
  endfunction

endpackage

// File: rtl/icache_fetch_responder_data_ram.sv
// Instruction data store: one write port, one registered read port (BRAM style).
module icache_data_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped read-only I-cache answering IF fetches; misses stall the core
// and refill a full line from backing memory.
module icache_fetch_responder
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic [31:0]       if_inst,
  output logic              if_valid,
  output logic              if_stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic [1:0]        dbg_state
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
  localparam int RAM_AW = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

  state_t               r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag_mem [NUM_LINES];
  logic [TAG_W-1:0]     r_tag_q;
  logic                 r_lk_valid;
  logic                 r_lk_flush;
  logic                 r_lk_vbit;
  logic [TAG_W-1:0]     r_lk_tag;
  logic [IDX_W-1:0]     r_lk_idx;
  logic [OFF_W-1:0]     r_lk_off;
  logic [OFF_W-1:0]     r_cnt;
  logic                 r_fill_flush;
  logic [31:0]          r_fill_word;
  logic                 r_mem_req_valid;
  logic [ADDR_W-1:0]    r_mem_req_addr;

  logic [TAG_W-1:0]     w_tag;
  logic [IDX_W-1:0]     w_idx;
  logic [OFF_W-1:0]     w_off;
  logic                 w_hit;
  logic                 w_miss;
  logic                 w_lookup;
  logic                 w_ram_we;
  logic                 w_last;
  logic [31:0]          w_ram_q;

  assign w_tag = TAG_W'(tag_of(64'(if_addr), OFF_W, IDX_W, TAG_W));
  assign w_idx = IDX_W'(index_of(64'(if_addr), OFF_W, IDX_W));
  assign w_off = OFF_W'(offset_of(64'(if_addr), OFF_W));

  // A lookup can only land while IDLE, so hit/miss never overlap a refill.
  assign w_hit    = r_lk_valid && r_lk_vbit && !r_lk_flush && (r_tag_q == r_lk_tag);
  assign w_miss   = r_lk_valid && !w_hit;
  assign w_lookup = if_req && (((r_state == IDLE) && !w_miss) || (r_state == RESP));
  assign w_ram_we = (r_state == FILL) && mem_resp_valid;
  assign w_last   = w_ram_we && (r_cnt == LAST_CNT);

  icache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .AW    (RAM_AW)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr ({r_lk_idx, r_cnt}),
    .i_wdata (mem_resp_data),
    .i_re    (w_lookup),
    .i_raddr ({w_idx, w_off}),
    .o_rdata (w_ram_q)
  );

  // Tag array is not reset; the valid flops guard it.
  always_ff @(posedge clk) begin
    if (w_last) r_tag_mem[r_lk_idx] <= r_lk_tag;
    if (w_lookup) r_tag_q <= r_tag_mem[w_idx];
  end

  // The lookup fields double as the latched miss address: nothing updates
  // them between miss detection and the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lk_valid <= 1'b0;
      r_lk_flush <= 1'b0;
      r_lk_vbit  <= 1'b0;
      r_lk_tag   <= '0;
      r_lk_idx   <= '0;
      r_lk_off   <= '0;
    end else begin
      r_lk_valid <= w_lookup;
      if (w_lookup) begin
        r_lk_flush <= flush;
        r_lk_vbit  <= r_valid[w_idx];
        r_lk_tag   <= w_tag;
        r_lk_idx   <= w_idx;
        r_lk_off   <= w_off;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (flush && ((r_state == IDLE) || (r_state == RESP))) begin
      r_valid <= '0;
    end else if (w_last && !r_fill_flush && !flush) begin
      r_valid[r_lk_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_cnt           <= '0;
      r_fill_flush    <= 1'b0;
      r_fill_word     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state         <= REQ;
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= {r_lk_tag, r_lk_idx, {(OFF_W + 2){1'b0}}};
            r_fill_flush    <= 1'b0;
          end
        end
        REQ: begin
          if (flush) r_fill_flush <= 1'b1;
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= FILL;
          end
        end
        FILL: begin
          if (flush) r_fill_flush <= 1'b1;
          if (mem_resp_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == r_lk_off) r_fill_word <= mem_resp_data;
            if (r_cnt == LAST_CNT) r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_valid      = w_hit || (r_state == RESP);
  assign if_inst       = (r_state == RESP) ? r_fill_word : (w_hit ? w_ram_q : 32'd0);
  assign if_stall      = w_miss || (r_state == REQ) || (r_state == FILL);
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder: misses, hit streaming,
// back-pressure, eviction, flush and reset during a refill.
module tb_icache_fetch_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        flush = 1'b0;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_stall;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [1:0]  dbg_state;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_accepts = 0;

  always #5 clk = ~clk;

  icache_fetch_responder dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .flush          (flush),
    .if_inst        (if_inst),
    .if_valid       (if_valid),
    .if_stall       (if_stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .dbg_state      (dbg_state)
  );

  // Inputs are stable here, so a handshake seen now is what the next edge takes.
  task automatic step();
    if (mem_req_valid && mem_req_ready) n_accepts++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] inst,
                        input logic st);
    chk({tag, "_valid"}, 32'(if_valid), 32'(v));
    chk({tag, "_inst"}, if_inst, inst);
    chk({tag, "_stall"}, 32'(if_stall), 32'(st));
  endtask

  // Fetch a missing address, hold REQ for 'hold' extra cycles, then grant.
  task automatic miss_request(input logic [31:0] a, input int hold);
    if_req = 1'b1;
    if_addr = a;
    step();
    chk_if("miss_detect", 1'b0, 32'd0, 1'b1);
    if_req = 1'b0;
    step();
    for (int i = 0; i < hold; i++) begin
      chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("req_hold_addr", mem_req_addr, a & 32'hFFFF_FFF0);
      step();
    end
    chk("req_valid", 32'(mem_req_valid), 32'd1);
    chk("req_addr", mem_req_addr, a & 32'hFFFF_FFF0);
    chk("req_stall", 32'(if_stall), 32'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("req_dropped", 32'(mem_req_valid), 32'd0);
    chk("fill_state", 32'(dbg_state), 32'd2);
  endtask

  // Return four words; optionally pulse flush alongside the second word.
  task automatic fill(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                      input logic [31:0] w3, input logic fl);
    logic [31:0] w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = w[i];
      flush          = fl && (i == 1);
      step();
      if (i < 3) chk("fill_stall", 32'(if_stall), 32'd1);
    end
    mem_resp_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic resp_check(input logic [31:0] inst);
    chk_if("resp", 1'b1, inst, 1'b0);
    chk("resp_state", 32'(dbg_state), 32'd3);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_if("reset", 1'b0, 32'd0, 1'b0);
    chk("reset_req_valid", 32'(mem_req_valid), 32'd0);
    chk("reset_req_addr", mem_req_addr, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    step();

    // Cold miss: 0x4000_0008 is offset 2 of the line at 0x4000_0000.
    miss_request(32'h4000_0008, 2);
    fill(32'h11, 32'h22, 32'h33, 32'h44, 1'b0);
    resp_check(32'h33);
    chk("cold_accepts", 32'(n_accepts), 32'd1);

    // Hit streaming, first lookup issued during RESP.
    if_req = 1'b1;
    if_addr = 32'h4000_0000;
    step();
    if_addr = 32'h4000_0004;
    chk_if("hit0", 1'b1, 32'h11, 1'b0);
    chk("hit0_noreq", 32'(mem_req_valid), 32'd0);
    step();
    if_addr = 32'h4000_000C;
    chk_if("hit1", 1'b1, 32'h22, 1'b0);
    chk("hit1_noreq", 32'(mem_req_valid), 32'd0);
    step();
    chk_if("hit2", 1'b1, 32'h44, 1'b0);
    chk("hit2_noreq", 32'(mem_req_valid), 32'd0);

    // Back-pressure: REQ held for 5 cycles with ready low.
    miss_request(32'h4000_0010, 5);
    fill(32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0);
    resp_check(32'hA0);
    chk("bp_accepts", 32'(n_accepts), 32'd2);

    // Conflict: same index 0, new tag, then the original line again.
    miss_request(32'h4000_0400, 0);
    fill(32'hB0, 32'hB1, 32'hB2, 32'hB3, 1'b0);
    resp_check(32'hB0);
    miss_request(32'h4000_0000, 0);
    fill(32'h11, 32'h22, 32'h33, 32'h44, 1'b0);
    resp_check(32'h11);

    // Flush in IDLE after a confirmed hit.
    if_req = 1'b1;
    if_addr = 32'h4000_0004;
    step();
    chk_if("pre_flush_hit", 1'b1, 32'h22, 1'b0);
    if_req = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    miss_request(32'h4000_0004, 0);
    // Flush during FILL: word still returned, line left invalid.
    fill(32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
    resp_check(32'h22);
    miss_request(32'h4000_0004, 0);
    fill(32'h11, 32'h22, 32'h33, 32'h44, 1'b0);
    resp_check(32'h22);
    step();

    // Reset after two of four refill words.
    miss_request(32'h4000_0020, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h55;
    step();
    mem_resp_data = 32'h66;
    step();
    rst = 1'b0;
    #1;
    chk_if("midrst", 1'b0, 32'd0, 1'b0);
    chk("midrst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_req_addr", mem_req_addr, 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    mem_resp_data = 32'hDEAD;
    step();
    rst = 1'b1;
    step();
    step();
    chk("stale_resp_state", 32'(dbg_state), 32'd0);
    chk_if("stale_resp", 1'b0, 32'd0, 1'b0);
    mem_resp_valid = 1'b0;
    // Line 0 was valid before reset; it must miss now.
    if_req = 1'b1;
    if_addr = 32'h4000_0004;
    step();
    chk_if("post_rst_miss", 1'b0, 32'd0, 1'b1);
    if_req = 1'b0;
    step();
    chk("post_rst_req_addr", mem_req_addr, 32'h4000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
